// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and a
// ceiling-log2 helper used for sizing pointers and counters.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Smallest r with 2**r >= value; log2(1) = 0.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; pushes when full and
// pops when empty are ignored.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int Depth = 16,
   parameter int Width = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [Width-1:0]       wr_data_i,
   output logic [Width-1:0]       rd_data_o,
   output logic [log2(Depth):0]   count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW    = log2(Depth);
   localparam int CNT_W = AW + 1;

   if (Depth < 2 || (1 << AW) != Depth) begin : g_bad_depth
      $error("uart_sync_fifo: Depth must be a power of two and at least 2");
   end

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o    = (count_q == CNT_W'(Depth));
   assign empty_o   = (count_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // NOTE: storage has no reset; only pointers and count define what is valid,
   // so a reset discards the contents without clearing every word.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // NOTE: every default is assigned before the case so no path leaves
   // count_d unassigned, which would otherwise infer a latch.
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // their inputs before any of them update on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes enter a FIFO over valid/ready and are sent
// as start, DataBits LSB first, optional parity and StopBits stop bits.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int ClkFrequency = 100000000,
   parameter int Baud         = 9600,
   parameter int DataBits     = 8,
   parameter int Parity       = 0,
   parameter int StopBits     = 2,
   parameter int FifoDepth    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic                     TxD,
   output logic                     TxD_busy,
   output logic [log2(FifoDepth):0] fifo_count
);

   localparam int DIV = (ClkFrequency + Baud / 2) / Baud;
   localparam int CW  = (log2(DIV) < 1) ? 1 : log2(DIV);
   localparam logic [7:0] DATA_MASK = 8'((1 << DataBits) - 1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_buffered: ClkFrequency/Baud gives a divider below 2");
   end
   if (DataBits < 5 || DataBits > 8) begin : g_bad_bits
      $error("uart_tx_buffered: DataBits must be 5..8");
   end
   if (Parity < 0 || Parity > 2) begin : g_bad_parity
      $error("uart_tx_buffered: Parity must be 0, 1 or 2");
   end
   if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
      $error("uart_tx_buffered: StopBits must be 1 or 2");
   end

   tx_state_e   state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        txd_q, txd_d;
   logic        tick, load, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_head;

   uart_sync_fifo #(
      .Depth (FifoDepth),
      .Width (8)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (tx_valid),
      .pop_i     (fifo_pop),
      .wr_data_i (tx_data),
      .rd_data_o (fifo_head),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign tick     = (baud_q == CW'(DIV - 1));
   assign tx_ready = !fifo_full;
   assign TxD      = txd_q;
   assign TxD_busy = (state_q != IDLE) || !fifo_empty;

   always_comb begin
      state_d   = state_q;
      baud_d    = tick ? '0 : baud_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      load      = 1'b0;

      case (state_q)
         IDLE:  load = !fifo_empty;
         START: if (tick) state_d = DATA;
         DATA: begin
            if (tick) begin
               if (bit_idx_q == 3'(DataBits - 1)) begin
                  bit_idx_d = '0;
                  state_d   = (Parity != PARITY_NONE) ? PARITY : STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               bit_idx_d = '0;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (bit_idx_q == 3'(StopBits - 1)) begin
                  // Chain straight into the next frame when data is waiting.
                  load    = !fifo_empty;
                  state_d = IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         shift_d   = fifo_head;
         par_d     = (^(fifo_head & DATA_MASK)) ^ (Parity == PARITY_ODD);
         baud_d    = '0;
         bit_idx_d = '0;
         state_d   = START;
      end
      fifo_pop = load;

      // The line is registered from the next state so it changes on the
      // same edge as the state it belongs to.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = par_d;
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         txd_q     <= txd_d;
      end
   end

endmodule
